// File: rtl/peak_frame_receiver_if.sv
// peak_frame_receiver_if
// Purpose: bundles the tx byte FIFO read side, the word output handshake and the
//          frame status signals of the peak frame receiver.
// Ports  : none; master = receiver side, slave = FIFO/downstream side.
interface peak_frame_receiver_if;
  // Byte FIFO read side
  logic        ByteAvail;
  logic        ByteValid;
  logic [7:0]  ByteIn;
  logic        ByteRdEn;
  // Word output handshake
  logic [15:0] WordOut;
  logic        WordValid;
  logic        WordReady;
  logic [8:0]  WordIndex;
  // Frame status
  logic        FrameStart;
  logic        FrameDone;
  logic [8:0]  FrameLen;
  logic        FrameError;
  logic [1:0]  ErrCode;
  logic [15:0] FrameCount;

  modport master (
    input  ByteAvail, ByteValid, ByteIn, WordReady,
    output ByteRdEn, WordOut, WordValid, WordIndex,
           FrameStart, FrameDone, FrameLen, FrameError, ErrCode, FrameCount
  );

  modport slave (
    output ByteAvail, ByteValid, ByteIn, WordReady,
    input  ByteRdEn, WordOut, WordValid, WordIndex,
           FrameStart, FrameDone, FrameLen, FrameError, ErrCode, FrameCount
  );
endinterface

// File: rtl/peak_frame_receiver.sv
// peak_frame_receiver
// Purpose     : pops the accumulator tx byte FIFO, finds FF 20 .. FF 80 frames and emits
//               16-bit MSB-first data words plus frame start/done/error status.
// Latency     : WordValid 1 cycle after the lo-byte ByteValid; FrameDone 1 cycle after the
//               stop-code byte; at most one FIFO read outstanding (1 byte per 2 cycles peak).
// Backpressure: WordOut/WordIndex held while WordValid & ~WordReady; no FIFO reads meanwhile.
// Ports:
//   SysClk, Reset    rising-edge clock, synchronous active-high reset
//   io_bus (master)  ByteAvail/ByteRdEn/ByteValid/ByteIn   tx FIFO read port
//                    WordOut/WordValid/WordReady/WordIndex  data word handshake
//                    FrameStart/FrameDone/FrameLen          frame boundary strobes + length
//                    FrameError/ErrCode/FrameCount          error pulse, sticky code, good frames
module peak_frame_receiver #(
  parameter logic [7:0]  MARKER     = 8'hFF,
  parameter logic [7:0]  START_CODE = 8'h20,
  parameter logic [7:0]  STOP_CODE  = 8'h80,
  parameter int unsigned MAX_WORDS  = 511,
  parameter int unsigned EXPECT_LEN = 0
) (
  input logic                   SysClk,
  input logic                   Reset,
  peak_frame_receiver_if.master io_bus
);

  localparam logic [9:0] MAX_W     = 10'(MAX_WORDS);
  localparam logic [8:0] EXP_L     = 9'(EXPECT_LEN);
  localparam bit         LEN_CHECK = (EXPECT_LEN != 0);

  localparam logic [1:0] ERR_LEN   = 2'd0;
  localparam logic [1:0] ERR_MARK  = 2'd1;
  localparam logic [1:0] ERR_OVF   = 2'd2;
  localparam logic [1:0] ERR_TRUNC = 2'd3;

  typedef enum logic [2:0] {
    S_HUNT,
    S_SYNC,
    S_FRAME_HI,
    S_FRAME_LO,
    S_EMIT,
    S_MARK_LO
  } state_t;

  state_t      r_state;
  logic        r_pending;
  logic [7:0]  r_hi;
  logic [15:0] r_word;
  logic        r_word_vld;
  logic [8:0]  r_index;
  logic        r_start;
  logic        r_done;
  logic [8:0]  r_len;
  logic        r_err;
  logic [1:0]  r_err_code;
  logic [15:0] r_count;

  state_t      w_state_nxt;
  logic [7:0]  w_hi;
  logic [15:0] w_word;
  logic        w_word_vld;
  logic [8:0]  w_index;
  logic        w_start;
  logic        w_done;
  logic [8:0]  w_len;
  logic        w_err;
  logic [1:0]  w_err_code;
  logic [15:0] w_count;

  logic        w_rd_en;
  logic        w_accept;
  logic [7:0]  w_byte;
  logic [9:0]  w_index_inc;

  // One read in flight at a time; reads are also held off while a word waits so that
  // a stalled downstream never makes us drop a byte. Reset gates the read so nothing
  // is popped from the FIFO while the receiver is being cleared.
  assign w_rd_en     = io_bus.ByteAvail & ~r_pending & (r_state != S_EMIT) & ~Reset;
  // A ByteValid with no read outstanding (e.g. from a read issued before reset) is ignored.
  assign w_accept    = io_bus.ByteValid & r_pending;
  assign w_byte      = io_bus.ByteIn;
  // One bit wider than the index so the MAX_WORDS == 511 compare cannot wrap.
  assign w_index_inc = {1'b0, r_index} + 10'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_hi        = r_hi;
    w_word      = r_word;
    w_word_vld  = r_word_vld;
    w_index     = r_index;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_len       = r_len;
    w_err       = 1'b0;
    w_err_code  = r_err_code;
    w_count     = r_count;

    unique case (r_state)
      S_HUNT: begin
        if (w_accept && (w_byte == MARKER)) begin
          w_state_nxt = S_SYNC;
        end
      end

      S_SYNC: begin
        if (w_accept) begin
          if (w_byte == START_CODE) begin
            w_state_nxt = S_FRAME_HI;
            w_index     = 9'd0;
            w_start     = 1'b1;
          end else if (w_byte != MARKER) begin
            // A repeated marker keeps us in sync; anything else was not a start word.
            w_state_nxt = S_HUNT;
          end
        end
      end

      S_FRAME_HI: begin
        if (w_accept) begin
          w_hi = w_byte;
          // Data words never carry MARKER in the high byte, so this is a control word.
          w_state_nxt = (w_byte == MARKER) ? S_MARK_LO : S_FRAME_LO;
        end
      end

      S_FRAME_LO: begin
        if (w_accept) begin
          w_word      = {r_hi, w_byte};
          w_word_vld  = 1'b1;
          w_state_nxt = S_EMIT;
        end
      end

      S_EMIT: begin
        if (io_bus.WordReady) begin
          w_word_vld = 1'b0;
          w_index    = w_index_inc[8:0];
          if (w_index_inc == MAX_W) begin
            w_err       = 1'b1;
            w_err_code  = ERR_OVF;
            w_state_nxt = S_HUNT;
          end else begin
            w_state_nxt = S_FRAME_HI;
          end
        end
      end

      S_MARK_LO: begin
        if (w_accept) begin
          if (w_byte == STOP_CODE) begin
            w_done      = 1'b1;
            w_len       = r_index;
            w_state_nxt = S_HUNT;
            if (LEN_CHECK && (r_index != EXP_L)) begin
              w_err      = 1'b1;
              w_err_code = ERR_LEN;
            end else begin
              w_count = r_count + 16'd1;
            end
          end else if (w_byte == START_CODE) begin
            // New frame started before the old one was closed: report and resync onto it.
            w_err       = 1'b1;
            w_err_code  = ERR_TRUNC;
            w_start     = 1'b1;
            w_index     = 9'd0;
            w_state_nxt = S_FRAME_HI;
          end else begin
            w_err       = 1'b1;
            w_err_code  = ERR_MARK;
            w_state_nxt = S_HUNT;
          end
        end
      end

      default: begin
        w_state_nxt = S_HUNT;
      end
    endcase
  end

  always_ff @(posedge SysClk) begin
    if (Reset) begin
      r_state    <= S_HUNT;
      r_pending  <= 1'b0;
      r_hi       <= 8'd0;
      r_word     <= 16'd0;
      r_word_vld <= 1'b0;
      r_index    <= 9'd0;
      r_start    <= 1'b0;
      r_done     <= 1'b0;
      r_len      <= 9'd0;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
      r_count    <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      if (w_rd_en) begin
        r_pending <= 1'b1;
      end else if (io_bus.ByteValid) begin
        r_pending <= 1'b0;
      end
      r_hi       <= w_hi;
      r_word     <= w_word;
      r_word_vld <= w_word_vld;
      r_index    <= w_index;
      r_start    <= w_start;
      r_done     <= w_done;
      r_len      <= w_len;
      r_err      <= w_err;
      r_err_code <= w_err_code;
      r_count    <= w_count;
    end
  end

  assign io_bus.ByteRdEn   = w_rd_en;
  assign io_bus.WordOut    = r_word;
  assign io_bus.WordValid  = r_word_vld;
  assign io_bus.WordIndex  = r_index;
  assign io_bus.FrameStart = r_start;
  assign io_bus.FrameDone  = r_done;
  assign io_bus.FrameLen   = r_len;
  assign io_bus.FrameError = r_err;
  assign io_bus.ErrCode    = r_err_code;
  assign io_bus.FrameCount = r_count;

endmodule
